sequenciador_rpn: RTL and testbench

Front-end sequencer that drives the RPN control decoder: turns the raw board push-buttons into clean single-cycle strobes and owns the 2-bit step counter.
- Synchronises and debounces the Enter and Reset keys.
- Emits one-clock Enter and Reset_borda pulses.
- Advances/clears Contagem exactly as the decoder expects, so Load strobes fire once per key press.
- Sits between the board keys and decodificadorRPN; also feeds step LEDs.

---
 rtl/sequenciador_rpn_if.sv | 27 ++
 rtl/sequenciador_rpn.sv | 139 +++++++++++++
 tb/tb_sequenciador_rpn.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_rpn_if.sv
// rtl/sequenciador_rpn_if.sv - key inputs and step/strobe outputs of the RPN front-end sequencer
interface sequenciador_rpn_if;
    logic       Key_enter_n;
    logic       Key_reset_n;
    logic [1:0] Contagem;
    logic       Enter;
    logic       Reset_borda;
    logic [3:0] Passo_led;

    modport master (
        output Key_enter_n,
        output Key_reset_n,
        input  Contagem,
        input  Enter,
        input  Reset_borda,
        input  Passo_led
    );

    modport slave (
        input  Key_enter_n,
        input  Key_reset_n,
        output Contagem,
        output Enter,
        output Reset_borda,
        output Passo_led
    );
endinterface

// File: rtl/sequenciador_rpn.sv
// rtl/sequenciador_rpn.sv - key sync/debounce, one-cycle Enter/Reset strobes and 2-bit RPN step counter
module sequenciador_rpn #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic               Clock,
    input logic               Reset_n,
    sequenciador_rpn_if.slave bus
);
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } step_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 of every per-key vector is Enter, bit 1 is Reset.
    logic [1:0]       key_raw;
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       flush_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [1:0]       deb_dly_q;
    logic [1:0]       arm_q;
    logic [1:0]       arm_d;
    logic [1:0]       fall;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             enter_q;
    logic             enter_d;
    logic             reset_borda_q;
    logic             reset_borda_d;
    step_e            state_q;
    step_e            state_d;
    logic [3:0]       led;

    assign key_raw = {bus.Key_reset_n, bus.Key_enter_n};

    // Two-flop synchronisers preset to the released level; flush_q marks when sync_q holds real key samples.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q  <= 2'b11;
            sync_q  <= 2'b11;
            flush_q <= 2'b00;
        end else begin
            meta_q  <= key_raw;
            sync_q  <= meta_q;
            flush_q <= {flush_q[0], 1'b1};
        end
    end

    // Debounce: a differing level must persist DEBOUNCE_CYCLES samples; a key arms only after a real release is seen.
    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    deb_d[k] = sync_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
        arm_d = arm_q | ({2{flush_q[1]}} & sync_q);
    end

    // Debounced levels, their one-cycle delayed copy for edge detection, and the arm flags.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            deb_q     <= 2'b11;
            deb_dly_q <= 2'b11;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            arm_q     <= 2'b00;
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            arm_q     <= arm_d;
        end
    end

    // Press edges become strobes; a simultaneous Reset press swallows the Enter press.
    always_comb begin
        fall          = deb_dly_q & ~deb_q & arm_q;
        reset_borda_d = fall[1];
        enter_d       = fall[0] & ~fall[1];
    end

    // Strobe registers keep outputs free of any path from the keys.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            enter_q       <= 1'b0;
            reset_borda_q <= 1'b0;
        end else begin
            enter_q       <= enter_d;
            reset_borda_q <= reset_borda_d;
        end
    end

    // Step state register; the state encoding is the Contagem value itself.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S00;
        end else begin
            state_q <= state_d;
        end
    end

    // Step holds during a strobe and moves on the edge that ends it; Reset wins over Enter.
    always_comb begin
        state_d = state_q;
        if (reset_borda_q) begin
            state_d = S00;
        end else if (enter_q) begin
            case (state_q)
                S00:     state_d = S01;
                S01:     state_d = S10;
                S10:     state_d = S11;
                S11:     state_d = S00;
                default: state_d = S00;
            endcase
        end
    end

    // One-hot step LEDs decoded from the step state.
    always_comb begin
        led = 4'b0001 << state_q;
    end

    assign bus.Contagem    = state_q;
    assign bus.Enter       = enter_q;
    assign bus.Reset_borda = reset_borda_q;
    assign bus.Passo_led   = led;
endmodule

// File: tb/tb_sequenciador_rpn.sv
// tb/tb_sequenciador_rpn.sv - directed bench with behavioural key/step model for sequenciador_rpn
module tb_sequenciador_rpn;
    localparam int DB = 4;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;

    sequenciador_rpn_if bus ();

    sequenciador_rpn #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    // Model state: key samples per edge (index 0 = newest), accepted levels, arm flags, strobes, step.
    bit he [DB+2];
    bit hr [DB+2];
    bit m_deb_e, m_deb_r, m_fall_e, m_fall_r, m_arm_e, m_arm_r, m_pe, m_pr;
    int m_t;
    int m_cnt;

    // Observations of the DUT for the hand-computed checks.
    int n_ent = 0;
    int n_rst = 0;
    int ent_cyc = 0;
    int rst_cont = 0;
    int ent_log [$];

    function automatic bit win_all(input bit h [DB+2], input bit v);
        for (int i = 2; i < DB + 2; i++) begin
            if (h[i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_t = 0;
        for (int i = 0; i < DB + 2; i++) begin
            he[i] = 1'b1;
            hr[i] = 1'b1;
        end
        m_deb_e = 1'b1; m_deb_r = 1'b1;
        m_fall_e = 1'b0; m_fall_r = 1'b0;
        m_arm_e = 1'b0; m_arm_r = 1'b0;
        m_pe = 1'b0; m_pr = 1'b0;
        m_cnt = 0;
    endtask

    // A level is accepted once DB consecutive synchronised samples (2 edges late) disagree with it;
    // a press strobe appears one edge after acceptance, only if the key was seen released since reset.
    task automatic model_edge();
        m_t++;
        if (m_pr) m_cnt = 0;
        else if (m_pe) m_cnt = (m_cnt + 1) % 4;
        m_pe = m_fall_e && m_arm_e && !(m_fall_r && m_arm_r);
        m_pr = m_fall_r && m_arm_r;
        for (int i = DB + 1; i > 0; i--) begin
            he[i] = he[i-1];
            hr[i] = hr[i-1];
        end
        he[0] = bus.Key_enter_n;
        hr[0] = bus.Key_reset_n;
        m_fall_e = m_deb_e && win_all(he, 1'b0);
        if (m_fall_e) m_deb_e = 1'b0;
        else if (!m_deb_e && win_all(he, 1'b1)) m_deb_e = 1'b1;
        m_fall_r = m_deb_r && win_all(hr, 1'b0);
        if (m_fall_r) m_deb_r = 1'b0;
        else if (!m_deb_r && win_all(hr, 1'b1)) m_deb_r = 1'b1;
        if (m_t >= 3 && he[2]) m_arm_e = 1'b1;
        if (m_t >= 3 && hr[2]) m_arm_r = 1'b1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge, then return for driving.
    task automatic tick();
        logic [3:0] exp_led;
        @(negedge Clock);
        if (!Reset_n) model_reset();
        exp_led = 4'b0001 << m_cnt;
        vectors++;
        if ({bus.Contagem, bus.Enter, bus.Reset_borda, bus.Passo_led} !==
            {m_cnt[1:0], m_pe, m_pr, exp_led}) begin
            fails++;
            $display("FAIL cycle %0d outputs: Contagem=%b Enter=%b Reset_borda=%b Passo_led=%b, expected %b %b %b %b",
                     cyc, bus.Contagem, bus.Enter, bus.Reset_borda, bus.Passo_led,
                     m_cnt[1:0], m_pe, m_pr, exp_led);
        end
        if (bus.Enter === 1'b1) begin
            n_ent++;
            ent_cyc = cyc;
            ent_log.push_back(int'(bus.Contagem));
        end
        if (bus.Reset_borda === 1'b1) begin
            n_rst++;
            rst_cont = int'(bus.Contagem);
        end
        @(posedge Clock);
        cyc++;
        if (!Reset_n) model_reset();
        else model_edge();
        #2;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic press_e();
        bus.Key_enter_n = 1'b0; wait_cyc(20);
        bus.Key_enter_n = 1'b1; wait_cyc(20);
    endtask

    task automatic press_r();
        bus.Key_reset_n = 1'b0; wait_cyc(20);
        bus.Key_reset_n = 1'b1; wait_cyc(20);
    endtask

    initial begin
        int e0, r0, c0;
        model_reset();
        bus.Key_enter_n = 1'b1;
        bus.Key_reset_n = 1'b1;
        wait_cyc(3);
        Reset_n = 1'b1;

        // Reset then idle
        wait_cyc(50);
        chk("idle Contagem", int'(bus.Contagem), 0);
        chk("idle Passo_led", int'(bus.Passo_led), 1);
        chk("idle pulses", n_ent + n_rst, 0);

        // Four clean Enter presses with wrap
        e0 = n_ent;
        ent_log.delete();
        repeat (4) press_e();
        chk("four presses count", n_ent - e0, 4);
        chk("step during press 1", ent_log[0], 0);
        chk("step during press 2", ent_log[1], 1);
        chk("step during press 3", ent_log[2], 2);
        chk("step during press 4", ent_log[3], 3);
        chk("wrap Contagem", int'(bus.Contagem), 0);

        // Bounce rejection then stable low
        e0 = n_ent;
        for (int i = 0; i < 20; i++) begin
            bus.Key_enter_n = ((i / 2) % 2) != 0;
            wait_cyc(1);
        end
        bus.Key_enter_n = 1'b0;
        c0 = cyc;
        wait_cyc(20);
        bus.Key_enter_n = 1'b1;
        wait_cyc(20);
        chk("bounce pulse count", n_ent - e0, 1);
        chk("bounce latency", ent_cyc - c0, 2 + DB + 1);

        // Reset mid-sequence
        press_r();
        press_e();
        press_e();
        chk("before reset Contagem", int'(bus.Contagem), 2);
        r0 = n_rst;
        e0 = n_ent;
        press_r();
        chk("reset pulse count", n_rst - r0, 1);
        chk("step during reset", rst_cont, 2);
        chk("after reset Contagem", int'(bus.Contagem), 0);
        chk("after reset Passo_led", int'(bus.Passo_led), 1);

        // Simultaneous press: Reset wins, Enter discarded
        press_e();
        r0 = n_rst;
        e0 = n_ent;
        bus.Key_enter_n = 1'b0;
        bus.Key_reset_n = 1'b0;
        wait_cyc(20);
        bus.Key_enter_n = 1'b1;
        bus.Key_reset_n = 1'b1;
        wait_cyc(20);
        chk("simult reset count", n_rst - r0, 1);
        chk("simult enter count", n_ent - e0, 0);
        chk("simult Contagem", int'(bus.Contagem), 0);

        // Async reset at debounce count 2 with key held through and after release of Reset_n
        press_e();
        e0 = n_ent;
        bus.Key_enter_n = 1'b0;
        wait_cyc(4);
        Reset_n = 1'b0;
        wait_cyc(2);
        Reset_n = 1'b1;
        wait_cyc(30);
        chk("held after reset pulses", n_ent - e0, 0);
        chk("held after reset Contagem", int'(bus.Contagem), 0);
        bus.Key_enter_n = 1'b1;
        wait_cyc(20);
        press_e();
        chk("repress after reset", n_ent - e0, 1);
        chk("repress Contagem", int'(bus.Contagem), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
